axi_write_master: RTL and testbench

AXI-style write-burst initiator that sits directly upstream of the write-side slave FSM and its memory. It takes one burst command (address, length, burst type) from a local controller and pulls write data from a valid/ready data source such as a FIFO. It drives the AW and W channels toward the slave, generates `m_wlast`, and samples the slave's combinational 3-bit write response on the last beat. It returns a one-cycle `done` pulse and a sticky `err` flag to the controller.

---
 rtl/axi_write_master.sv | 100 ++++++++++
 tb/tb_axi_write_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_master.sv
// AXI-style write-burst initiator: latches one burst command, streams source data onto the
// W channel, drives AW concurrently and reports done/err from the last-beat response.
module axi_write_master #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [1:0]        cmd_burst,
   input  logic [DATA_W-1:0] src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic [7:0]        m_awlen,
   output logic [1:0]        m_awburst,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wlast,
   input  logic [2:0]        b_resp,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic {StIdle, StXfer} state_t;

   localparam logic [2:0] RespOkay = 3'b100;

   state_t     state_q;
   logic [7:0] beat_cnt_q;
   logic       aw_done_q;
   logic       xfer;
   logic       w_hs;

   assign xfer      = (state_q == StXfer);
   assign busy      = xfer;
   assign cmd_ready = !xfer;
   assign m_wvalid  = xfer && src_valid;
   assign src_ready = xfer && m_wready;
   assign m_wdata   = src_data;
   assign m_wlast   = xfer && (beat_cnt_q == m_awlen);
   assign w_hs      = m_wvalid && m_wready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         beat_cnt_q <= 8'd0;
         aw_done_q  <= 1'b0;
         m_awvalid  <= 1'b0;
         m_awaddr   <= '0;
         m_awlen    <= 8'd0;
         m_awburst  <= 2'b00;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  m_awaddr   <= cmd_addr;
                  m_awlen    <= cmd_len;
                  m_awburst  <= cmd_burst;
                  m_awvalid  <= 1'b1;
                  beat_cnt_q <= 8'd0;
                  aw_done_q  <= 1'b0;
                  err        <= 1'b0;
                  state_q    <= StXfer;
               end
            end
            StXfer: begin
               if (m_awvalid && m_awready) begin
                  m_awvalid <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  if (m_wlast) begin
                     // The slave may accept AW in the very cycle of the last beat.
                     err       <= (b_resp != RespOkay) || !(aw_done_q || m_awready);
                     done      <= 1'b1;
                     m_awvalid <= 1'b0;
                     state_q   <= StIdle;
                  end else begin
                     // Held at the final index so a 256-beat burst never wraps.
                     beat_cnt_q <= beat_cnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_write_master.sv
// Self-checking bench for axi_write_master: randomized directed bursts checked every cycle
// against a burst-level reference model (beats issued, AW seen, expected done/err).
module tb_axi_write_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [1:0]  cmd_burst;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [1:0]  m_awburst;
   logic        m_wvalid;
   logic        m_wready;
   logic [31:0] m_wdata;
   logic        m_wlast;
   logic [2:0]  b_resp;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the burst should look like from the controller's view.
   bit          mb_busy;
   int          mb_sent;
   int          mb_len;
   logic [31:0] mb_addr;
   logic [1:0]  mb_burst;
   bit          mb_aw_pending;
   bit          mb_aw_seen;
   bit          mb_done;
   bit          mb_err;

   bit obs_beat;
   bit obs_last;

   axi_write_master #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_awlen(m_awlen), .m_awburst(m_awburst),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
      .b_resp(b_resp), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mb_busy = 0; mb_sent = 0; mb_len = 0; mb_addr = '0; mb_burst = 2'b00;
      mb_aw_pending = 0; mb_aw_seen = 0; mb_done = 0; mb_err = 0;
   endtask

   task automatic check_outputs();
      chk("cmd_ready", cmd_ready, !mb_busy);
      chk("busy", busy, mb_busy);
      chk("src_ready", src_ready, mb_busy && m_wready);
      chk("m_wvalid", m_wvalid, mb_busy && src_valid);
      chk("m_wlast", m_wlast, mb_busy && (mb_sent == mb_len));
      chk("m_awvalid", m_awvalid, mb_aw_pending);
      chk("m_awaddr", m_awaddr, mb_addr);
      chk("m_awlen", m_awlen, mb_len[7:0]);
      chk("m_awburst", m_awburst, mb_burst);
      chk("done", done, mb_done);
      chk("err", err, mb_err);
      if (mb_busy && src_valid) chk("m_wdata", m_wdata, src_data);
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step();
      bit beat;
      #1;
      check_outputs();
      obs_beat = m_wvalid && src_ready;
      obs_last = obs_beat && m_wlast;
      @(posedge clk);
      mb_done = 0;
      if (!mb_busy) begin
         if (cmd_valid) begin
            mb_busy = 1; mb_sent = 0; mb_len = int'(cmd_len);
            mb_addr = cmd_addr; mb_burst = cmd_burst;
            mb_aw_pending = 1; mb_aw_seen = 0; mb_err = 0;
         end
      end else begin
         beat = src_valid && m_wready;
         if (mb_aw_pending && m_awready) begin
            mb_aw_pending = 0;
            mb_aw_seen = 1;
         end
         if (beat) begin
            mb_sent++;
            if (mb_sent == mb_len + 1) begin
               mb_err = (b_resp != 3'b100) || !mb_aw_seen;
               mb_done = 1;
               mb_busy = 0;
               mb_aw_pending = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) begin
         cmd_valid = 0; src_valid = 1'($urandom); m_wready = 1'($urandom);
         m_awready = 1'($urandom); src_data = $urandom; b_resp = 3'($urandom);
         step();
      end
   endtask

   // sv_mode: 0 continuous, 1 toggling, 2 random. wr_mode: 0 ready, 1 mid-burst stall,
   // 2 random. aw_mode: 0 early, 1 never, 2 with last beat, 3 random.
   task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input int sv_mode, input int wr_mode, input int aw_mode,
                            input bit bad, input bit check_latency);
      int  n = 0;
      int  beats = 0;
      int  lasts = 0;
      bit  fin = 0;
      bit  lastbeat;
      cmd_valid = 1; cmd_addr = addr; cmd_len = 8'(len); cmd_burst = burst;
      src_valid = 1'($urandom); m_wready = 1'($urandom); m_awready = 1'($urandom);
      src_data = $urandom; b_resp = 3'($urandom);
      step();
      while (!fin && n < 3000) begin
         // Commands offered mid-burst must be ignored.
         cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_len = 8'($urandom);
         cmd_burst = 2'($urandom);
         case (sv_mode)
            0: src_valid = 1;
            1: src_valid = (n % 2 == 0);
            default: src_valid = ($urandom_range(0, 3) != 0);
         endcase
         case (wr_mode)
            0: m_wready = 1;
            1: m_wready = !(n >= 3 && n < 6);
            default: m_wready = ($urandom_range(0, 3) != 0);
         endcase
         src_data = $urandom;
         lastbeat = (mb_sent == mb_len) && src_valid && m_wready;
         case (aw_mode)
            0: m_awready = (n >= 1);
            1: m_awready = 0;
            2: m_awready = lastbeat;
            default: m_awready = 1'($urandom);
         endcase
         b_resp = lastbeat ? (bad ? 3'b111 : 3'b100) : 3'($urandom);
         step();
         if (obs_beat) beats++;
         if (obs_last) lasts++;
         fin = mb_done;
         n++;
      end
      chk("burst_finished", fin, 1);
      chk("beat_count", beats, len + 1);
      chk("wlast_count", lasts, 1);
      if (check_latency) chk("done_latency", n, len + 1);
   endtask

   initial begin
      rst_n = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_burst = '0;
      src_data = '0; src_valid = 0; m_awready = 0; m_wready = 0; b_resp = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs();
      rst_n = 1;
      idle_steps(3);

      // Single INCR burst, continuous source, ready slave.
      run_burst(32'h100, 3, 2'b01, 0, 0, 0, 0, 1);
      idle_steps(2);
      // Toggling source with a 3-cycle slave stall.
      run_burst(32'h2000, 7, 2'b01, 1, 1, 3, 0, 0);
      // Error response, then back-to-back command in the done cycle clears err.
      run_burst(32'h3000, 2, 2'b01, 0, 0, 2, 1, 1);
      run_burst(32'h3100, 1, 2'b00, 0, 0, 2, 0, 1);
      // AW never accepted.
      run_burst(32'h4000, 4, 2'b01, 0, 0, 1, 0, 1);
      idle_steps(1);
      // Boundaries.
      run_burst(32'h5000, 0, 2'b01, 0, 0, 2, 0, 1);
      run_burst(32'h6000, 255, 2'b01, 0, 0, 2, 0, 1);
      idle_steps(2);

      // Reset after 2 of 6 beats.
      cmd_valid = 1; cmd_addr = 32'h7000; cmd_len = 8'd5; cmd_burst = 2'b01;
      src_valid = 1; m_wready = 1; m_awready = 0; b_resp = 3'b100;
      step();
      cmd_valid = 0;
      step();
      step();
      rst_n = 0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst_n = 1;
      idle_steps(3);
      run_burst(32'h7100, 5, 2'b01, 0, 0, 0, 0, 1);

      // Randomized bursts.
      for (int i = 0; i < 8; i++) begin
         run_burst($urandom, $urandom_range(0, 20), 2'($urandom), 2, 2, 3,
                   ($urandom_range(0, 2) == 0), 0);
         if ($urandom_range(0, 1) == 1) idle_steps($urandom_range(1, 3));
      end
      idle_steps(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
